// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: datapath width, NOP encoding and FSM states.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StFlush
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; the head word reads as zero while empty.
module sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [Width-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [Width-1:0]       rd_data,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_wr, do_rd;

  always_comb begin
    do_wr = wr_en && (count_q != (PtrW+1)'(Depth));
    do_rd = rd_en && (count_q != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_wr && !do_rd) begin
        count_q <= count_q + (PtrW+1)'(1);
      end else if (do_rd && !do_wr) begin
        count_q <= count_q - (PtrW+1)'(1);
      end
    end
  end

  // Storage carries no reset; the empty gate below hides stale words.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count   = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request stream, in-order prefetch buffer and
// redirect flush that discards responses still in flight.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q;
  logic [XLEN-1:0]   fetch_pc_q;
  logic [CntW-1:0]   discard_q, discard_d;
  logic [CntW-1:0]   buf_count, pcq_count;
  logic [CntW:0]     credit_used;
  logic [XLEN-1:0]   pcq_head;
  logic [2*XLEN-1:0] buf_head;
  logic              req_fire, rsp_keep, pop;

  // In-flight requests = live ones (PC queue) + ones already marked for discard.
  always_comb begin
    credit_used    = {1'b0, buf_count} + {1'b0, pcq_count} + {1'b0, discard_q};
    imem_req_valid = (state_q != StBoot) && !redirect_valid &&
                     (credit_used < (CntW+1)'(FIFO_DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_keep       = imem_rsp_valid && !redirect_valid && (state_q != StFlush);
    pop            = if_valid && if_ready;
    discard_d      = pcq_count + discard_q - CntW'(imem_rsp_valid);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StBoot;
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else if (redirect_valid) begin
      fetch_pc_q <= redirect_pc & ~XLEN'(3);
      discard_q  <= discard_d;
      state_q    <= (discard_d != '0) ? StFlush : StFetch;
    end else begin
      if (req_fire) fetch_pc_q <= fetch_pc_q + XLEN'(4);
      unique case (state_q)
        StBoot:  state_q <= StFetch;
        StFetch: state_q <= StFetch;
        StFlush: begin
          if (imem_rsp_valid) begin
            discard_q <= discard_q - CntW'(1);
            if (discard_q == CntW'(1)) state_q <= StFetch;
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  sync_fifo #(
    .Width(2 * XLEN),
    .Depth(FIFO_DEPTH)
  ) u_instr_buf (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (redirect_valid),
    .wr_en  (rsp_keep),
    .wr_data({pcq_head, imem_rsp_data}),
    .rd_en  (pop),
    .rd_data(buf_head),
    .count  (buf_count)
  );

  sync_fifo #(
    .Width(XLEN),
    .Depth(FIFO_DEPTH)
  ) u_pc_queue (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (redirect_valid),
    .wr_en  (req_fire),
    .wr_data(fetch_pc_q),
    .rd_en  (rsp_keep),
    .rd_data(pcq_head),
    .count  (pcq_count)
  );

  assign imem_req_addr = fetch_pc_q;
  assign if_valid      = (buf_count != '0);
  assign if_instr      = buf_head[XLEN-1:0];
  assign if_pc         = buf_head[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed multi-cycle sequences, a redirect vector table and random
// traffic checked every cycle against a queue-based reference model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    bit          discard;
  } flight_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic        exp_req_valid;
    logic        exp_if_valid;
  } redir_vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_if_valid;
  logic [31:0] w_if_instr, w_if_pc;

  int checks, errors, cyc, last_due, lat_lo, lat_hi, fire_count;

  flight_t     m_flight[$];
  entry_t      m_buf[$];
  mreq_t       memq[$];
  logic [31:0] m_pc;
  bit          m_boot;

  logic        s_req_valid, s_if_valid, s_w_valid;
  logic [31:0] s_req_addr, s_if_pc, s_w_pc, s_w_instr;

  redir_vec_t vecs [5];

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc)
  );

  fetch_unit #(
    .RESET_PC  (32'hFFFF_FFF8),
    .FIFO_DEPTH(DEPTH)
  ) dut_wrap (
    .clk           (clk),
    .reset_n       (reset_n),
    .redirect_valid(1'b0),
    .redirect_pc   (32'h0),
    .imem_req_valid(w_req_valid),
    .imem_req_ready(1'b1),
    .imem_req_addr (w_req_addr),
    .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data (w_rsp_data),
    .if_valid      (w_if_valid),
    .if_ready      (1'b1),
    .if_instr      (w_if_instr),
    .if_pc         (w_if_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Reference model: compare this cycle's outputs, then advance across the clock edge.
  task automatic model_step();
    logic    er, ev;
    flight_t f;
    entry_t  e;
    er = !m_boot && !redirect_valid && ((m_buf.size() + m_flight.size()) < int'(DEPTH));
    ev = (m_buf.size() != 0);
    chk1("req_valid", imem_req_valid, er);
    if (er) chk("req_addr", imem_req_addr, m_pc);
    chk1("if_valid", if_valid, ev);
    if (ev) begin
      chk("if_pc", if_pc, m_buf[0].pc);
      chk("if_instr", if_instr, m_buf[0].instr);
      if (if_ready) void'(m_buf.pop_front());
    end
    if (imem_rsp_valid && m_flight.size() != 0) begin
      f = m_flight.pop_front();
      if (!redirect_valid && !f.discard) begin
        e.pc    = f.pc;
        e.instr = mem_word(f.pc);
        m_buf.push_back(e);
      end
    end
    if (er && imem_req_ready) begin
      f.pc      = m_pc;
      f.discard = 1'b0;
      m_flight.push_back(f);
      m_pc = m_pc + 32'd4;
    end
    if (redirect_valid) begin
      m_buf.delete();
      foreach (m_flight[i]) m_flight[i].discard = 1'b1;
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end
    m_boot = 1'b0;
  endtask

  task automatic tick();
    logic        fire, w_fire;
    logic [31:0] addr, w_addr;
    mreq_t       m;
    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_if_valid  = if_valid;
    s_if_pc     = if_pc;
    s_w_valid   = w_if_valid;
    s_w_pc      = w_if_pc;
    s_w_instr   = w_if_instr;
    model_step();
    fire   = imem_req_valid && imem_req_ready;
    addr   = imem_req_addr;
    w_fire = w_req_valid;
    w_addr = w_req_addr;
    if (fire) fire_count++;
    @(posedge clk);
    #1;
    if (fire) begin
      m.due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (m.due <= last_due) m.due = last_due + 1;
      m.addr = addr;
      memq.push_back(m);
      last_due = m.due;
    end
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = INSTR_NOP;
    if (memq.size() != 0 && memq[0].due == cyc) begin
      m = memq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(m.addr);
    end
    w_rsp_valid    = w_fire;
    w_rsp_data     = mem_word(w_addr);
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = INSTR_NOP;
    w_rsp_valid    = 1'b0;
    w_rsp_data     = INSTR_NOP;
    memq.delete();
    m_buf.delete();
    m_flight.delete();
    m_pc     = 32'h0;
    m_boot   = 1'b1;
    last_due = -1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_wrap_req_addr", w_req_addr, 32'hFFFF_FFF8);
    reset_n    = 1'b1;
    cyc        = 0;
    fire_count = 0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0203, 32'h0000_0200, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0100, 32'h0000_0100, 1'b1, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b1, 1'b0};
    vecs[3] = '{32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4] = '{32'h8000_0006, 32'h8000_0004, 1'b1, 1'b0};

    checks         = 0;
    errors         = 0;
    cyc            = 0;
    lat_lo         = 1;
    lat_hi         = 1;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;

    // Streaming at latency 1, plus the wrap-around instance.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c >= 3 && c <= 6) begin
        chk1("stream_if_valid", s_if_valid, 1'b1);
        chk("stream_if_pc", s_if_pc, 32'(4 * (c - 3)));
      end
      if (c >= 3 && c <= 5) begin
        chk1("wrap_if_valid", s_w_valid, 1'b1);
        chk("wrap_if_pc", s_w_pc, 32'hFFFF_FFF8 + 32'(4 * (c - 3)));
        chk("wrap_if_instr", s_w_instr, mem_word(32'hFFFF_FFF8 + 32'(4 * (c - 3))));
      end
    end

    // Consumer stalled: credit limit caps issued requests.
    do_reset();
    if_ready = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("stall_req_count", 32'(fire_count), 32'd4);
    chk1("stall_if_valid", s_if_valid, 1'b1);
    chk("stall_if_pc", s_if_pc, 32'h0);
    chk1("stall_req_valid", s_req_valid, 1'b0);
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
    tick();
    chk1("stall_release_req", s_req_valid, 1'b1);

    // Asynchronous reset with three buffered entries, then restart.
    do_reset();
    if_ready = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk1("pre_rst_if_valid", if_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk1("async_rst_if_valid", if_valid, 1'b0);
    chk1("async_rst_req_valid", imem_req_valid, 1'b0);
    chk("async_rst_if_pc", if_pc, 32'h0);
    chk("async_rst_if_instr", if_instr, 32'h0);
    chk("async_rst_req_addr", imem_req_addr, 32'h0);
    do_reset();
    if_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 3) begin
        chk1("restart_if_valid", s_if_valid, 1'b1);
        chk("restart_if_pc", s_if_pc, 32'h0);
      end
    end

    // Latency 3: redirect with two requests in flight.
    do_reset();
    lat_lo   = 3;
    lat_hi   = 3;
    if_ready = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    chk1("flush_redirect_req", s_req_valid, 1'b0);
    for (int c = 4; c < 8; c++) begin
      tick();
      chk1("flush_gap_if_valid", s_if_valid, 1'b0);
    end
    tick();
    chk1("flush_first_valid", s_if_valid, 1'b1);
    chk("flush_first_pc", s_if_pc, 32'h0000_0100);

    // Redirect vector table at latency 1.
    do_reset();
    lat_lo = 1;
    lat_hi = 1;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      redirect_valid = 1'b1;
      redirect_pc    = vecs[i].rpc;
      tick();
      tick();
      chk("vec_req_addr", s_req_addr, vecs[i].exp_addr);
      chk1("vec_req_valid", s_req_valid, vecs[i].exp_req_valid);
      chk1("vec_if_valid", s_if_valid, vecs[i].exp_if_valid);
      repeat (3) tick();
    end

    // Random traffic against the reference model.
    do_reset();
    lat_lo = 1;
    lat_hi = 4;
    for (int c = 0; c < 1500; c++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      if_ready       = ($urandom_range(2, 0) != 0);
      if ($urandom_range(15, 0) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom_range(1, 0) != 0) ? $urandom
                                                     : (32'hFFFF_FFF0 | ($urandom & 32'hF));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
